// File: rtl/ldst_mem_interface_pkg.sv
// Shared types for the LSQ-to-dcache interface: request struct, FSM states,
// RV32I load/store funct3 encodings and the access-size decode used by the datapath.
package ldst_mem_interface_pkg;

  localparam int LDST_ROB_ENTRIES = 8;
  localparam int LDST_TAG_W       = $clog2(LDST_ROB_ENTRIES);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    ST_WAIT,
    DRAIN
  } ldst_mem_state_t;

  typedef struct packed {
    logic                  is_store;
    logic [2:0]            funct3;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [LDST_TAG_W-1:0] tag;
  } ldst_req_t;

  // Unlisted funct3 codes (3/6/7, and 4/5 for stores) fall through to word access.
  function automatic access_size_t access_size(input logic is_store, input logic [2:0] funct3);
    access_size_t size;
    size = SZ_WORD;
    if (is_store) begin
      if (funct3 == F3_SB)      size = SZ_BYTE;
      else if (funct3 == F3_SH) size = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU)      size = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) size = SZ_HALF;
    end
    return size;
  endfunction

  function automatic logic is_misaligned(input logic is_store, input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (access_size(is_store, funct3))
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ldst_align.sv
// Combinational lane logic: byte enables and lane-replicated store data on the way out,
// byte/halfword extraction with sign or zero extension on the way back.
module ldst_align
  import ldst_mem_interface_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mbe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_val
);

  access_size_t w_size;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;

  always_comb begin
    w_size = access_size(i_is_store, i_funct3);

    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_mbe   = 4'b1111;
    o_wdata = i_wdata;
    if (i_is_store) begin
      case (w_size)
        SZ_BYTE: begin
          o_mbe   = 4'b0001 << i_off;
          o_wdata = {4{i_wdata[7:0]}};
        end
        SZ_HALF: begin
          o_mbe   = 4'b0011 << {i_off[1], 1'b0};
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_mbe   = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end

    // funct3[2] marks the unsigned load variants.
    case (w_size)
      SZ_BYTE: o_load_val = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load_val = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load_val = i_rdata;
    endcase
  end

endmodule

// File: rtl/ldst_mem_interface.sv
// Single-outstanding LSQ-to-dcache bridge with registered outputs and flush draining.
// Optional misaligned-access trap is enabled by defining LDST_MISALIGN_TRAP_EN.
module ldst_mem_interface
  import ldst_mem_interface_pkg::*;
#(
  parameter  int ROB_ENTRIES = LDST_ROB_ENTRIES,
  localparam int TAG_W       = $clog2(ROB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             data_read,
  output logic             data_write,
  output logic [3:0]       data_mbe,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_resp,
  input  logic [31:0]      data_rdata,
  output logic             load_res_valid,
  output logic [TAG_W-1:0] load_res_tag,
  output logic [31:0]      load_res_value,
  output logic             store_done,
  output logic [TAG_W-1:0] store_done_tag
`ifdef LDST_MISALIGN_TRAP_EN
  ,
  output logic             misalign_err,
  output logic [TAG_W-1:0] misalign_tag
`endif
);

  ldst_mem_state_t  r_state;
  ldst_req_t        r_req;
  logic             r_ready;
  logic             r_read;
  logic             r_write;
  logic [3:0]       r_mbe;
  logic [31:0]      r_wdata;
  logic             r_ld_valid;
  logic [TAG_W-1:0] r_ld_tag;
  logic [31:0]      r_ld_value;
  logic             r_st_done;
  logic [TAG_W-1:0] r_st_tag;
`ifdef LDST_MISALIGN_TRAP_EN
  logic             r_mis_err;
  logic [TAG_W-1:0] r_mis_tag;
`endif

  ldst_req_t   w_req;
  logic        w_idle;
  logic        w_accept;
  logic        w_misaligned;
  logic        w_is_store;
  logic [2:0]  w_funct3;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [3:0]  w_mbe;
  logic [31:0] w_shifted;
  logic [31:0] w_load_val;

  assign w_req    = '{is_store: req_is_store, funct3: req_funct3, addr: req_addr,
                      wdata: req_wdata, tag: req_tag};
  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid && r_ready && !flush;

  // The aligner is shared: in IDLE it shapes the incoming request, otherwise it
  // extracts load data using the latched op.
  assign w_is_store = w_idle ? w_req.is_store : r_req.is_store;
  assign w_funct3   = w_idle ? w_req.funct3   : r_req.funct3;
  assign w_off      = w_idle ? w_req.addr[1:0] : r_req.addr[1:0];
  assign w_wdata    = w_idle ? w_req.wdata    : r_req.wdata;

`ifdef LDST_MISALIGN_TRAP_EN
  assign w_misaligned = is_misaligned(req_is_store, req_funct3, req_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  ldst_align u_align (
    .i_is_store (w_is_store),
    .i_funct3   (w_funct3),
    .i_off      (w_off),
    .i_wdata    (w_wdata),
    .i_rdata    (data_rdata),
    .o_mbe      (w_mbe),
    .o_wdata    (w_shifted),
    .o_load_val (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_ready    <= 1'b1;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_mbe      <= 4'b0000;
      r_wdata    <= 32'h0;
      r_ld_valid <= 1'b0;
      r_ld_tag   <= '0;
      r_ld_value <= 32'h0;
      r_st_done  <= 1'b0;
      r_st_tag   <= '0;
`ifdef LDST_MISALIGN_TRAP_EN
      r_mis_err  <= 1'b0;
      r_mis_tag  <= '0;
`endif
    end else begin
      r_ld_valid <= 1'b0;
      r_st_done  <= 1'b0;
`ifdef LDST_MISALIGN_TRAP_EN
      r_mis_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
`ifdef LDST_MISALIGN_TRAP_EN
              r_mis_err <= 1'b1;
              r_mis_tag <= req_tag;
`endif
            end else begin
              r_req   <= w_req;
              r_mbe   <= w_mbe;
              r_wdata <= w_shifted;
              r_read  <= !req_is_store;
              r_write <= req_is_store;
              r_ready <= 1'b0;
              r_state <= req_is_store ? ST_WAIT : LD_WAIT;
            end
          end
        end
        LD_WAIT, ST_WAIT: begin
          if (data_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
            if (!flush) begin
              if (r_state == LD_WAIT) begin
                r_ld_valid <= 1'b1;
                r_ld_tag   <= r_req.tag;
                r_ld_value <= w_load_val;
              end else begin
                r_st_done  <= 1'b1;
                r_st_tag   <= r_req.tag;
              end
            end
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        // The cache cannot abort, so a flushed op keeps its strobe up until it completes.
        DRAIN: begin
          if (data_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = r_ready;
  assign data_read      = r_read;
  assign data_write     = r_write;
  assign data_mbe       = r_mbe;
  assign data_addr      = {r_req.addr[31:2], 2'b00};
  assign data_wdata     = r_wdata;
  assign load_res_valid = r_ld_valid;
  assign load_res_tag   = r_ld_tag;
  assign load_res_value = r_ld_value;
  assign store_done     = r_st_done;
  assign store_done_tag = r_st_tag;
`ifdef LDST_MISALIGN_TRAP_EN
  assign misalign_err   = r_mis_err;
  assign misalign_tag   = r_mis_tag;
`endif

endmodule

// File: tb/tb_ldst_mem_interface.sv
// Directed self-checking bench for ldst_mem_interface; expected values are hand-computed.
// Covers the LDST_MISALIGN_TRAP_EN build as well as the default build.
module tb_ldst_mem_interface;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_tag;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        load_res_valid;
  logic [2:0]  load_res_tag;
  logic [31:0] load_res_value;
  logic        store_done;
  logic [2:0]  store_done_tag;
`ifdef LDST_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic [2:0]  misalign_tag;
`endif

  int testsRun;
  int testsFailed;

  ldst_mem_interface #(.ROB_ENTRIES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_tag        (req_tag),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_mbe       (data_mbe),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_resp      (data_resp),
    .data_rdata     (data_rdata),
    .load_res_valid (load_res_valid),
    .load_res_tag   (load_res_tag),
    .load_res_value (load_res_value),
    .store_done     (store_done),
    .store_done_tag (store_done_tag)
`ifdef LDST_MISALIGN_TRAP_EN
    ,
    .misalign_err   (misalign_err),
    .misalign_tag   (misalign_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge, then drop req_valid.
  task automatic applyStimulus(input logic isStore, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] tag);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_tag      = tag;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    data_resp  = 1'b1;
    data_rdata = rdata;
    tick();
    data_resp  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    testsRun++; if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    testsRun++; if ({data_read, data_write, load_res_valid, store_done} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {data_read, data_write, load_res_valid, store_done}); end
    testsRun++; if ({data_addr, data_wdata, data_mbe} !== 68'h0) begin testsFailed++; $display("[TB] FAIL reset_bus: got %h expected 0", {data_addr, data_wdata, data_mbe}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_word;
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 3'd5);
    testsRun++; if (data_read !== 1'b1 || data_write !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_strobe: got rd=%b wr=%b expected rd=1 wr=0", data_read, data_write); end
    testsRun++; if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_busy: got %b expected 0", req_ready); end
    repeat (2) tick();
    testsRun++; if (data_addr !== 32'h0000_0100 || data_mbe !== 4'hF || data_read !== 1'b1) begin testsFailed++; $display("[TB] FAIL lw_held: got addr=%h mbe=%h rd=%b expected 00000100 f 1", data_addr, data_mbe, data_read); end
    respond(32'hDEAD_BEEF);
    testsRun++; if (load_res_valid !== 1'b1 || load_res_value !== 32'hDEAD_BEEF || load_res_tag !== 3'd5) begin testsFailed++; $display("[TB] FAIL lw_result: got v=%b val=%h tag=%0d expected 1 deadbeef 5", load_res_valid, load_res_value, load_res_tag); end
    testsRun++; if (req_ready !== 1'b1 || data_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_release: got rdy=%b rd=%b expected 1 0", req_ready, data_read); end
    tick();
    testsRun++; if (load_res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_pulse: got %b expected 0", load_res_valid); end
  endtask

  task automatic test_load_extend;
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 3'd1);
    respond(32'h80FF_FFFF);
    testsRun++; if (load_res_value !== 32'hFFFF_FF80) begin testsFailed++; $display("[TB] FAIL lb_sext: got %h expected ffffff80", load_res_value); end
    applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 3'd2);
    respond(32'h80FF_FFFF);
    testsRun++; if (load_res_value !== 32'h0000_0080) begin testsFailed++; $display("[TB] FAIL lbu_zext: got %h expected 00000080", load_res_value); end
    applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 3'd3);
    respond(32'h80FF_FFFF);
    testsRun++; if (load_res_value !== 32'h0000_80FF) begin testsFailed++; $display("[TB] FAIL lhu_zext: got %h expected 000080ff", load_res_value); end
    applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0, 3'd4);
    respond(32'h80FF_1234);
    testsRun++; if (load_res_value !== 32'hFFFF_80FF || load_res_tag !== 3'd4) begin testsFailed++; $display("[TB] FAIL lh_sext: got %h tag=%0d expected ffff80ff 4", load_res_value, load_res_tag); end
  endtask

  task automatic test_store;
    applyStimulus(1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 3'd2);
    testsRun++; if (data_write !== 1'b1 || data_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_strobe: got wr=%b rd=%b expected 1 0", data_write, data_read); end
    testsRun++; if (data_addr !== 32'h0000_0200 || data_mbe !== 4'b0010 || data_wdata !== 32'h7878_7878) begin testsFailed++; $display("[TB] FAIL sb_bus: got addr=%h mbe=%b wd=%h expected 00000200 0010 78787878", data_addr, data_mbe, data_wdata); end
    tick();
    respond(32'h0);
    testsRun++; if (store_done !== 1'b1 || store_done_tag !== 3'd2 || load_res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_done: got sd=%b tag=%0d lv=%b expected 1 2 0", store_done, store_done_tag, load_res_valid); end
    tick();
    testsRun++; if (store_done !== 1'b0 || data_write !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_pulse: got sd=%b wr=%b expected 0 0", store_done, data_write); end
    applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'hAABB_CCDD, 3'd6);
    testsRun++; if (data_mbe !== 4'b1100 || data_wdata !== 32'hCCDD_CCDD) begin testsFailed++; $display("[TB] FAIL sh_bus: got mbe=%b wd=%h expected 1100 ccddccdd", data_mbe, data_wdata); end
    respond(32'h0);
    testsRun++; if (store_done !== 1'b1 || store_done_tag !== 3'd6) begin testsFailed++; $display("[TB] FAIL sh_done: got sd=%b tag=%0d expected 1 6", store_done, store_done_tag); end
  endtask

  task automatic test_flush_wait;
    applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0, 3'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    testsRun++; if (data_read !== 1'b1 || req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_hold: got rd=%b rdy=%b expected 1 0", data_read, req_ready); end
    tick();
    testsRun++; if (data_read !== 1'b1 || req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_hold: got rd=%b rdy=%b expected 1 0", data_read, req_ready); end
    respond(32'h5555_5555);
    testsRun++; if (load_res_valid !== 1'b0 || req_ready !== 1'b1 || data_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_done: got lv=%b rdy=%b rd=%b expected 0 1 0", load_res_valid, req_ready, data_read); end
    applyStimulus(1'b0, 3'b010, 32'h0000_0500, 32'h0, 3'd4);
    flush = 1'b1;
    respond(32'h6666_6666);
    flush = 1'b0;
    testsRun++; if (load_res_valid !== 1'b0 || req_ready !== 1'b1 || data_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_resp: got lv=%b rdy=%b rd=%b expected 0 1 0", load_res_valid, req_ready, data_read); end
    flush = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'h0, 3'd5);
    flush = 1'b0;
    testsRun++; if (data_read !== 1'b0 || req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_idle: got rd=%b rdy=%b expected 0 1", data_read, req_ready); end
  endtask

  task automatic test_reset_mid_op;
    applyStimulus(1'b1, 3'b010, 32'h0000_0700, 32'hCAFE_0001, 3'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    testsRun++; if (data_write !== 1'b0 || req_ready !== 1'b1 || data_addr !== 32'h0 || data_mbe !== 4'h0 || data_wdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL rst_mid: got wr=%b rdy=%b addr=%h mbe=%h wd=%h expected 0 1 0 0 0", data_write, req_ready, data_addr, data_mbe, data_wdata); end
    respond(32'h0);
    testsRun++; if (store_done !== 1'b0 || load_res_valid !== 1'b0 || req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL resp_idle: got sd=%b lv=%b rdy=%b expected 0 0 1", store_done, load_res_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    applyStimulus(1'b0, 3'b010, 32'h0000_0800, 32'h0, 3'd1);
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0300;
    req_tag      = 3'd3;
    respond(32'h1122_3344);
    testsRun++; if (load_res_valid !== 1'b1 || load_res_tag !== 3'd1 || load_res_value !== 32'h1122_3344 || req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_first: got lv=%b tag=%0d val=%h rdy=%b expected 1 1 11223344 1", load_res_valid, load_res_tag, load_res_value, req_ready); end
    tick();
    req_valid = 1'b0;
    testsRun++; if (data_read !== 1'b1 || data_addr !== 32'h0000_0300 || load_res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_second: got rd=%b addr=%h lv=%b expected 1 00000300 0", data_read, data_addr, load_res_valid); end
    respond(32'h0BAD_F00D);
    testsRun++; if (load_res_tag !== 3'd3 || load_res_value !== 32'h0BAD_F00D) begin testsFailed++; $display("[TB] FAIL b2b_result: got tag=%0d val=%h expected 3 0badf00d", load_res_tag, load_res_value); end
  endtask

  task automatic test_misalign;
    applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'h0, 3'd7);
`ifdef LDST_MISALIGN_TRAP_EN
    testsRun++; if (data_read !== 1'b0 || misalign_err !== 1'b1 || misalign_tag !== 3'd7 || req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_trap: got rd=%b err=%b tag=%0d rdy=%b expected 0 1 7 1", data_read, misalign_err, misalign_tag, req_ready); end
    tick();
    testsRun++; if (misalign_err !== 1'b0 || data_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_pulse: got err=%b rd=%b expected 0 0", misalign_err, data_read); end
`else
    testsRun++; if (data_read !== 1'b1 || data_addr !== 32'h0000_0100 || data_mbe !== 4'hF) begin testsFailed++; $display("[TB] FAIL mis_ignored: got rd=%b addr=%h mbe=%h expected 1 00000100 f", data_read, data_addr, data_mbe); end
    respond(32'hCAFE_F00D);
    testsRun++; if (load_res_valid !== 1'b1 || load_res_value !== 32'hCAFE_F00D || load_res_tag !== 3'd7) begin testsFailed++; $display("[TB] FAIL mis_word: got lv=%b val=%h tag=%0d expected 1 cafef00d 7", load_res_valid, load_res_value, load_res_tag); end
`endif
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_tag      = 3'd0;
    data_resp    = 1'b0;
    data_rdata   = 32'h0;

    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_flush_wait();
    test_reset_mid_op();
    test_back_to_back();
    test_misalign();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
